// File: rtl/stream_fifo_reader.sv
// First-word-fall-through stream FIFO: simple dual-port RAM with a registered
// read port whose output register doubles as the consumer-facing head word.

module stream_fifo_reader_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];

  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;

  // Read register holds its value when no read is issued.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
endmodule

module stream_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH:0]   level
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH:0] wptr, rptr, mcount;
  logic                push, fetch;

  // Extra pointer bit distinguishes full from empty in the RAM.
  assign mcount = wptr - rptr;
  assign wready = (mcount != DEPTH);
  assign push   = wvalid & wready & ~clear;
  assign fetch  = (mcount != '0) & (~rvalid | rready) & ~clear;
  assign level  = mcount + {{ADDR_WIDTH{1'b0}}, rvalid};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr   <= '0;
      rptr   <= '0;
      rvalid <= 1'b0;
    end else if (clear) begin
      wptr   <= '0;
      rptr   <= '0;
      rvalid <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + 1'b1;
      if (fetch) rptr <= rptr + 1'b1;
      if (fetch)                rvalid <= 1'b1;
      else if (rvalid & rready) rvalid <= 1'b0;
    end
  end

  // Fetch and write never share an address, so no bypass is needed.
  stream_fifo_reader_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock  (clock),
    .resetn (resetn),
    .we     (push),
    .waddr  (wptr[ADDR_WIDTH-1:0]),
    .wdata  (wdata),
    .re     (fetch),
    .raddr  (rptr[ADDR_WIDTH-1:0]),
    .rdata  (rdata)
  );
endmodule

// File: tb/tb_stream_fifo_reader.sv
// Directed + random scoreboard bench for stream_fifo_reader (DATA_WIDTH=8, ADDR_WIDTH=4).
module tb_stream_fifo_reader;
  logic       clock = 1'b0;
  logic       resetn, clear, wvalid, wready, rvalid, rready;
  logic [7:0] wdata, rdata;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;
  int nacc   = 0;
  int npop   = 0;
  bit last_aw;
  logic [7:0] q[$];

  stream_fifo_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear),
    .wvalid (wvalid),
    .wready (wready),
    .wdata  (wdata),
    .rvalid (rvalid),
    .rready (rready),
    .rdata  (rdata),
    .level  (level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven: scores the handshakes
  // that the coming posedge will take, then returns at the next negedge.
  task automatic cyc();
    bit aw, ar;
    logic [7:0] e;
    #1;
    aw = wvalid && wready && !clear;
    ar = rvalid && rready && !clear;
    last_aw = aw;
    if (ar) begin
      npop++;
      if (q.size() == 0) chk("pop_on_empty_model", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("rdata", rdata, e);
      end
    end
    if (aw) begin
      q.push_back(wdata);
      nacc++;
    end
    if (clear) q.delete();
    @(posedge clock);
    @(negedge clock);
    chk("level", level, q.size());
  endtask

  initial begin
    int budget, pops0;
    resetn = 1'b0; clear = 1'b0; wvalid = 1'b0; rready = 1'b0; wdata = '0;
    #12;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata",  rdata,  0);
    chk("rst_level",  level,  0);
    chk("rst_wready", wready, 1);
    @(negedge clock);
    resetn = 1'b1;

    // Single word: accepted at one edge, fetched in the next cycle, shown after that edge.
    wvalid = 1'b1; wdata = 8'hA5;
    cyc();
    wvalid = 1'b0;
    chk("single_rvalid_early", rvalid, 0);
    chk("single_wready", wready, 1);
    cyc();
    chk("single_rvalid", rvalid, 1);
    chk("single_rdata", rdata, 8'hA5);
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    chk("single_drained", rvalid, 0);

    // Fill to 17 words under backpressure; 18th offer must be refused.
    nacc = 0;
    for (int i = 0; i < 17; i++) begin
      wvalid = 1'b1; wdata = 8'(i);
      cyc();
    end
    chk("fill_accepts", nacc, 17);
    chk("full_wready", wready, 0);
    chk("full_level", level, 17);
    wdata = 8'h11;
    cyc();
    chk("full_refuse", nacc, 17);
    wvalid = 1'b0;

    // Drain 17 words back to back.
    rready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk("drain_rvalid", rvalid, 1);
      cyc();
      if (i == 0) chk("drain_wready", wready, 1);
    end
    rready = 1'b0;
    chk("drain_empty_rvalid", rvalid, 0);
    chk("drain_empty_level", level, 0);
    chk("drain_empty_wready", wready, 1);

    // Streaming 100 words with wvalid=rready=1: 98 pops inside the window.
    pops0 = npop;
    wvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wdata = 8'(8'h20 + i);
      cyc();
      chk("stream_level_le2", (level <= 2), 1);
    end
    chk("stream_pops", npop - pops0, 98);
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("stream_total", npop - pops0, 100);

    // Random valid/ready for 10000 accepted words; producer holds data while stalled.
    nacc = 0; budget = 0; last_aw = 1'b1; wvalid = 1'b0;
    while (nacc < 10000 && budget < 60000) begin
      if (!(wvalid && !last_aw)) begin
        wvalid = 1'($urandom_range(0, 1));
        wdata  = 8'($urandom);
      end
      rready = 1'($urandom_range(0, 1));
      cyc();
      budget++;
    end
    chk("rand_accepts", nacc, 10000);
    wvalid = 1'b0; rready = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 40) begin
      cyc();
      budget++;
    end
    chk("rand_drained", q.size(), 0);
    cyc();
    chk("rand_rvalid_end", rvalid, 0);
    rready = 1'b0;

    // Clear at level 9 with both handshakes active.
    for (int i = 0; i < 9; i++) begin
      wvalid = 1'b1; wdata = 8'(8'h80 + i);
      cyc();
    end
    chk("pre_clear_level", level, 9);
    wvalid = 1'b1; rready = 1'b1; clear = 1'b1; wdata = 8'hEE;
    cyc();
    clear = 1'b0; rready = 1'b0;
    chk("clear_rvalid", rvalid, 0);
    chk("clear_level", level, 0);
    chk("clear_wready", wready, 1);
    wvalid = 1'b1; wdata = 8'h3C;
    cyc();
    wvalid = 1'b0;
    cyc();
    chk("post_clear_rvalid", rvalid, 1);
    chk("post_clear_rdata", rdata, 8'h3C);

    // Asynchronous reset in the middle of a burst.
    wvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 8'(8'h50 + i);
      cyc();
    end
    #3;
    resetn = 1'b0;
    #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_level",  level,  0);
    chk("midrst_wready", wready, 1);
    chk("midrst_rdata",  rdata,  0);
    q.delete();
    wvalid = 1'b0; rready = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    wvalid = 1'b1; wdata = 8'h77;
    cyc();
    wvalid = 1'b0;
    cyc();
    chk("after_rst_rdata", rdata, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
